// File: rtl/chimera_pkg.sv
// Shared types and sizing helpers for the cluster power-management sequencer.
package chimera_pkg;

  localparam int unsigned DefExtClusters     = 5;
  localparam int unsigned DefClkSettleCycles = 4;
  localparam int unsigned DefRstCycles       = 8;
  localparam int unsigned DefAckTimeout      = 256;

  typedef enum logic [3:0] {
    PMU_ON,
    PMU_ISO_ON,
    PMU_GATE_ON,
    PMU_RST_ON,
    PMU_OFF,
    PMU_UNGATE,
    PMU_UNRST,
    PMU_DEISO,
    PMU_FAULT
  } pmu_state_e;

  function automatic int unsigned pmu_cnt_w(input int unsigned settle,
                                            input int unsigned rst_cyc,
                                            input int unsigned ack_to);
    int unsigned m;
    m = settle;
    if (rst_cyc > m) m = rst_cyc;
    if (ack_to > m) m = ack_to;
    return $clog2(m + 1);
  endfunction

  localparam int unsigned PmuCntW =
    pmu_cnt_w(DefClkSettleCycles, DefRstCycles, DefAckTimeout);

  // Stable states are the only ones that can take a new command.
  function automatic logic pmu_is_idle(input pmu_state_e s);
    return (s == PMU_ON) || (s == PMU_OFF) || (s == PMU_FAULT);
  endfunction

endpackage

// File: rtl/chimera_pmu_clu_fsm.sv
// One cluster's power sequence: state machine, step counter and registered PMU controls.
module chimera_pmu_clu_fsm
  import chimera_pkg::*;
#(
  parameter int unsigned ClkSettleCycles = DefClkSettleCycles,
  parameter int unsigned RstCycles       = DefRstCycles,
  parameter int unsigned AckTimeout      = DefAckTimeout
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  input  logic       i_cmd_on,
  input  logic       i_iso_ack,
  output logic       o_rst_n,
  output logic       o_clkgate_en,
  output logic       o_iso_en,
  output logic       o_busy,
  output logic       o_off,
  output logic       o_fault,
  output pmu_state_e o_state
);

  localparam int unsigned CntW = pmu_cnt_w(ClkSettleCycles, RstCycles, AckTimeout);
  localparam logic [CntW-1:0] CntSettle = CntW'(ClkSettleCycles);
  localparam logic [CntW-1:0] CntRst    = CntW'(RstCycles);
  localparam logic [CntW-1:0] CntAck    = CntW'(AckTimeout);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  pmu_state_e      r_state, w_next;
  logic [CntW-1:0] r_cnt, w_cnt_next, w_cnt_dec;
  logic            r_rst_n, r_gate, r_iso, r_busy, r_off, r_fault;
  logic            w_rst_n_d, w_gate_d, w_iso_d, w_busy_d, w_off_d, w_fault_d;

  assign w_cnt_dec = r_cnt - CntOne;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= PMU_ON;
      r_cnt   <= '0;
      r_rst_n <= 1'b1;
      r_gate  <= 1'b0;
      r_iso   <= 1'b0;
      r_busy  <= 1'b0;
      r_off   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_rst_n <= w_rst_n_d;
      r_gate  <= w_gate_d;
      r_iso   <= w_iso_d;
      r_busy  <= w_busy_d;
      r_off   <= w_off_d;
      r_fault <= w_fault_d;
    end
  end

  // Timed steps leave when the counter would hit zero, so a load of N gives N cycles;
  // ack waits time out only once the counter has actually reached zero.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      PMU_ON: begin
        if (i_cmd_valid && !i_cmd_on) begin
          w_next     = PMU_ISO_ON;
          w_cnt_next = CntAck;
        end
      end
      PMU_ISO_ON: begin
        if (i_iso_ack) begin
          w_next     = PMU_GATE_ON;
          w_cnt_next = CntSettle;
        end else if (r_cnt == '0) begin
          w_next = PMU_FAULT;
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end
      PMU_GATE_ON: begin
        if (r_cnt <= CntOne) begin
          w_next     = PMU_RST_ON;
          w_cnt_next = CntRst;
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end
      PMU_RST_ON: begin
        if (r_cnt <= CntOne) w_next = PMU_OFF;
        else w_cnt_next = w_cnt_dec;
      end
      PMU_OFF: begin
        if (i_cmd_valid && i_cmd_on) begin
          w_next     = PMU_UNGATE;
          w_cnt_next = CntSettle;
        end
      end
      PMU_UNGATE: begin
        if (r_cnt <= CntOne) begin
          w_next     = PMU_UNRST;
          w_cnt_next = CntRst;
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end
      PMU_UNRST: begin
        if (r_cnt <= CntOne) begin
          w_next     = PMU_DEISO;
          w_cnt_next = CntAck;
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end
      PMU_DEISO: begin
        if (!i_iso_ack) begin
          w_next = PMU_ON;
        end else if (r_cnt == '0) begin
          w_next = PMU_FAULT;
        end else begin
          w_cnt_next = w_cnt_dec;
        end
      end
      PMU_FAULT: begin
        if (i_cmd_valid && i_cmd_on) begin
          w_next     = PMU_UNGATE;
          w_cnt_next = CntSettle;
        end else if (i_cmd_valid) begin
          w_next = PMU_OFF;
        end
      end
      default: w_next = PMU_ON;
    endcase
  end

  // Controls are decoded from the next state and registered, so they track the state exactly.
  always_comb begin
    w_rst_n_d = 1'b1;
    w_gate_d  = 1'b0;
    w_iso_d   = 1'b0;
    w_busy_d  = 1'b1;
    w_off_d   = 1'b0;
    w_fault_d = 1'b0;
    case (w_next)
      PMU_ON:      w_busy_d = 1'b0;
      PMU_ISO_ON:  w_iso_d = 1'b1;
      PMU_GATE_ON: begin w_gate_d = 1'b1; w_iso_d = 1'b1; end
      PMU_RST_ON:  begin w_rst_n_d = 1'b0; w_gate_d = 1'b1; w_iso_d = 1'b1; end
      PMU_OFF: begin
        w_rst_n_d = 1'b0; w_gate_d = 1'b1; w_iso_d = 1'b1; w_busy_d = 1'b0; w_off_d = 1'b1;
      end
      PMU_UNGATE:  begin w_rst_n_d = 1'b0; w_iso_d = 1'b1; end
      PMU_UNRST:   w_iso_d = 1'b1;
      PMU_DEISO:   w_busy_d = 1'b1;
      PMU_FAULT: begin
        w_rst_n_d = 1'b0; w_gate_d = 1'b1; w_iso_d = 1'b1; w_busy_d = 1'b0; w_fault_d = 1'b1;
      end
      default:     w_busy_d = 1'b0;
    endcase
  end

  assign o_rst_n      = r_rst_n;
  assign o_clkgate_en = r_gate;
  assign o_iso_en     = r_iso;
  assign o_busy       = r_busy;
  assign o_off        = r_off;
  assign o_fault      = r_fault;
  assign o_state      = r_state;

endmodule

// File: rtl/chimera_pmu_seq.sv
// Command front-end for the per-cluster power sequencers: decode, back-pressure and index errors.
module chimera_pmu_seq
  import chimera_pkg::*;
#(
  parameter int unsigned ExtClusters     = DefExtClusters,
  parameter int unsigned ClkSettleCycles = DefClkSettleCycles,
  parameter int unsigned RstCycles       = DefRstCycles,
  parameter int unsigned AckTimeout      = DefAckTimeout,
  localparam int unsigned CluIdxW        = (ExtClusters > 1) ? $clog2(ExtClusters) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [CluIdxW-1:0]     cmd_cluster_i,
  input  logic                   cmd_on_i,
  output logic                   cmd_err_o,
  input  logic [ExtClusters-1:0] iso_ack_clusters_i,
  output logic [ExtClusters-1:0] rst_clusters_no,
  output logic [ExtClusters-1:0] clkgate_en_clusters_o,
  output logic [ExtClusters-1:0] iso_en_clusters_o,
  output logic [ExtClusters-1:0] busy_o,
  output logic [ExtClusters-1:0] off_o,
  output logic [ExtClusters-1:0] fault_o
);

  // Handshake: a command transfers on a cycle where cmd_valid_i && cmd_ready_o; ready depends
  // only on the addressed cluster being in a stable state (or the index being out of range).
  pmu_state_e             w_state [ExtClusters];
  logic [ExtClusters-1:0] w_idle, w_cmd_valid;
  logic                   w_idx_ok, w_accept;
  logic                   r_cmd_err;

  assign w_idx_ok = (32'(cmd_cluster_i) < ExtClusters);

  always_comb begin
    cmd_ready_o = 1'b1;
    if (w_idx_ok) cmd_ready_o = w_idle[cmd_cluster_i];
  end

  assign w_accept = cmd_valid_i && cmd_ready_o;

  for (genvar gi = 0; gi < ExtClusters; gi++) begin : g_clu
    assign w_idle[gi]      = pmu_is_idle(w_state[gi]);
    assign w_cmd_valid[gi] = w_accept && w_idx_ok && (cmd_cluster_i == CluIdxW'(gi));

    chimera_pmu_clu_fsm #(
      .ClkSettleCycles(ClkSettleCycles),
      .RstCycles      (RstCycles),
      .AckTimeout     (AckTimeout)
    ) u_fsm (
      .i_clk       (clk_i),
      .i_rst       (rst_i),
      .i_cmd_valid (w_cmd_valid[gi]),
      .i_cmd_on    (cmd_on_i),
      .i_iso_ack   (iso_ack_clusters_i[gi]),
      .o_rst_n     (rst_clusters_no[gi]),
      .o_clkgate_en(clkgate_en_clusters_o[gi]),
      .o_iso_en    (iso_en_clusters_o[gi]),
      .o_busy      (busy_o[gi]),
      .o_off       (off_o[gi]),
      .o_fault     (fault_o[gi]),
      .o_state     (w_state[gi])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_cmd_err <= 1'b0;
    else       r_cmd_err <= w_accept && !w_idx_ok;
  end

  assign cmd_err_o = r_cmd_err;

endmodule

// File: tb/tb_chimera_pmu_seq.sv
// Bench for chimera_pmu_seq: timeline reference model, per-cluster expected queues, change monitor.
module tb_chimera_pmu_seq;

  localparam int NCLU   = 5;
  localparam int SETTLE = 4;
  localparam int RSTC   = 8;
  localparam int ACK_TO = 256;
  localparam int NEVER  = 100000;
  localparam int M_ON = 0, M_OFF = 1, M_FAULT = 2;

  // snapshot = {rst_n, clkgate, iso, busy, off, fault}
  localparam logic [5:0] S_ON   = 6'b100000;
  localparam logic [5:0] S_ISO  = 6'b101100;
  localparam logic [5:0] S_GATE = 6'b111100;
  localparam logic [5:0] S_RST  = 6'b011100;
  localparam logic [5:0] S_OFF  = 6'b011010;
  localparam logic [5:0] S_UNG  = 6'b001100;
  localparam logic [5:0] S_UNR  = 6'b101100;
  localparam logic [5:0] S_DEI  = 6'b100100;
  localparam logic [5:0] S_FLT  = 6'b011001;

  logic            clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_on = 1'b0;
  logic [2:0]      cmd_cluster = '0;
  logic            cmd_ready, cmd_err;
  logic [NCLU-1:0] iso_ack = '0;
  logic [NCLU-1:0] rst_n, gate, iso, busy, off, fault;

  chimera_pmu_seq dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .cmd_valid_i          (cmd_valid),
    .cmd_ready_o          (cmd_ready),
    .cmd_cluster_i        (cmd_cluster),
    .cmd_on_i             (cmd_on),
    .cmd_err_o            (cmd_err),
    .iso_ack_clusters_i   (iso_ack),
    .rst_clusters_no      (rst_n),
    .clkgate_en_clusters_o(gate),
    .iso_en_clusters_o    (iso),
    .busy_o               (busy),
    .off_o                (off),
    .fault_o              (fault)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          total = 0, bad = 0;
  logic [37:0] exp_q [NCLU][$];
  logic [31:0] err_q[$];
  int          m_state [NCLU];
  int          stable_at [NCLU];
  logic        ack_final [NCLU];
  int          ack_cyc [NCLU];
  logic        ack_val [NCLU];
  bit          mon_en = 0;

  function automatic logic [5:0] snap(input int c);
    return {rst_n[c], gate[c], iso[c], busy[c], off[c], fault[c]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp_v, cyc);
    end
  endtask

  function automatic void push_ev(input int c, input int t, input logic [5:0] v);
    exp_q[c].push_back({32'(t), v});
  endfunction

  // Reference model: the timeline of output changes one accepted command produces.
  function automatic void model_cmd(input int c, input bit on, input int t0, input int dly);
    int d, t, td;
    if (c >= NCLU) begin
      err_q.push_back(32'(t0 + 1));
      return;
    end
    if (!on) begin
      if (m_state[c] == M_OFF) return;
      if (m_state[c] == M_FAULT) begin
        push_ev(c, t0 + 1, S_OFF);
        m_state[c] = M_OFF; stable_at[c] = t0 + 1;
        return;
      end
      push_ev(c, t0 + 1, S_ISO);
      d = ack_final[c] ? 0 : dly;
      if (d > ACK_TO) begin
        push_ev(c, t0 + 2 + ACK_TO, S_FLT);
        m_state[c] = M_FAULT; stable_at[c] = t0 + 2 + ACK_TO;
      end else begin
        if (!ack_final[c]) begin
          ack_cyc[c] = t0 + 1 + d; ack_val[c] = 1'b1; ack_final[c] = 1'b1;
        end
        t = t0 + 2 + d;
        push_ev(c, t, S_GATE);
        push_ev(c, t + SETTLE, S_RST);
        push_ev(c, t + SETTLE + RSTC, S_OFF);
        m_state[c] = M_OFF; stable_at[c] = t + SETTLE + RSTC;
      end
    end else begin
      if (m_state[c] == M_ON) return;
      push_ev(c, t0 + 1, S_UNG);
      push_ev(c, t0 + 1 + SETTLE, S_UNR);
      td = t0 + 1 + SETTLE + RSTC;
      push_ev(c, td, S_DEI);
      d = ack_final[c] ? dly : 0;
      if (ack_final[c]) begin
        ack_cyc[c] = td + d; ack_val[c] = 1'b0; ack_final[c] = 1'b0;
      end
      push_ev(c, td + 1 + d, S_ON);
      m_state[c] = M_ON; stable_at[c] = td + 1 + d;
    end
  endfunction

  // ---------------- cluster-domain ack responder ----------------
  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCLU; c++)
        if (ack_cyc[c] == cyc) iso_ack[c] = ack_val[c];
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [5:0]  prev [NCLU];
    logic [5:0]  s;
    logic [37:0] e;
    logic [31:0] et;
    wait (mon_en);
    for (int c = 0; c < NCLU; c++) prev[c] = snap(c);
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCLU; c++) begin
        s = snap(c);
        if (s !== prev[c]) begin
          if (exp_q[c].size() == 0) begin
            check($sformatf("unexpected_change_c%0d", c), s, prev[c]);
          end else begin
            e = exp_q[c].pop_front();
            check($sformatf("event_cycle_c%0d", c), cyc, e[37:6]);
            check($sformatf("event_value_c%0d", c), s, e[5:0]);
          end
          prev[c] = s;
        end else if (exp_q[c].size() != 0 && int'(exp_q[c][0][37:6]) < cyc) begin
          e = exp_q[c].pop_front();
          check($sformatf("missed_event_c%0d_val%0h", c, e[5:0]), cyc, e[37:6]);
        end
      end
      if (cmd_err === 1'b1) begin
        if (err_q.size() == 0) check("cmd_err_unexpected", cmd_err, 1'b0);
        else begin
          et = err_q.pop_front();
          check("cmd_err_cycle", cyc, et);
        end
      end else if (err_q.size() != 0 && int'(err_q[0]) < cyc) begin
        et = err_q.pop_front();
        check("cmd_err_missed", cmd_err, 1'b1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int c, input bit on, input int dly, output int t_acc);
    bit exp_rdy;
    int budget;
    budget = 0;
    t_acc  = -1;
    forever begin
      @(negedge clk);
      cmd_cluster = 3'(c); cmd_on = on; cmd_valid = 1'b1;
      #1;
      exp_rdy = (c >= NCLU) || (cyc >= stable_at[c]);
      check($sformatf("cmd_ready_c%0d", c), cmd_ready, exp_rdy);
      if (exp_rdy) break;
      budget++;
      if (budget > 3000) begin
        total++; bad++;
        $display("FAIL issue_timeout_c%0d: ready never expected at cycle %0d", c, cyc);
        cmd_valid = 1'b0;
        return;
      end
    end
    t_acc = cyc;
    model_cmd(c, on, cyc, dly);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_all_idle();
    int t;
    t = 0;
    for (int c = 0; c < NCLU; c++) if (stable_at[c] > t) t = stable_at[c];
    wait_until(t + 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t, c, d;
    bit on;
    for (int i = 0; i < NCLU; i++) begin
      m_state[i] = M_ON; stable_at[i] = 0; ack_final[i] = 1'b0;
      ack_cyc[i] = -1; ack_val[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < NCLU; i++) check($sformatf("reset_snap_c%0d", i), snap(i), S_ON);
    check("reset_cmd_err", cmd_err, 1'b0);
    cmd_cluster = 3'd0; #1;
    check("reset_ready_c0", cmd_ready, 1'b1);
    cmd_cluster = 3'd7; #1;
    check("reset_ready_c7", cmd_ready, 1'b1);
    mon_en = 1;

    // power-down then power-up of cluster 2
    issue(2, 1'b0, 3, t);
    wait_until(stable_at[2]);
    issue(2, 1'b1, 2, t);
    wait_until(stable_at[2] + 1);
    check("busy_c2_after_on", busy[2], 1'b0);

    // ack timeout on cluster 0, then recovery
    issue(0, 1'b0, NEVER, t);
    wait_until(stable_at[0] + 1);
    check("fault_c0", fault[0], 1'b1);
    issue(0, 1'b1, 3, t);
    wait_until(stable_at[0]);

    // back-pressure on busy cluster 1 while cluster 3 is accepted
    issue(1, 1'b0, 1, t);
    wait_until(t + 4);
    issue(3, 1'b0, 2, t);
    issue(1, 1'b1, 2, t);
    issue(3, 1'b1, 1, t);

    // out-of-range indices
    issue(7, 1'b1, 0, t);
    issue(5, 1'b0, 0, t);

    // reset in the middle of RST_ON
    wait_all_idle();
    issue(1, 1'b0, 0, t);
    wait_until(t + 8);
    #2;
    rst = 1'b1;
    for (int i = 0; i < NCLU; i++) begin
      exp_q[i].delete();
      if (!(m_state[i] == M_ON && stable_at[i] <= cyc)) push_ev(i, cyc + 1, S_ON);
      m_state[i] = M_ON; stable_at[i] = cyc + 1;
    end
    err_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 120; i++) begin
      c  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      on = 1'($urandom_range(0, 1));
      d  = $urandom_range(0, 5);
      issue(c, on, d, t);
    end

    // drain
    for (int w = 0; w < 600; w++) begin
      @(negedge clk);
      if (err_q.size() == 0 && exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
          exp_q[2].size() == 0 && exp_q[3].size() == 0 && exp_q[4].size() == 0) break;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NCLU; i++) check($sformatf("drained_c%0d", i), exp_q[i].size(), 0);
    check("drained_err", err_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
